// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor, a - b, LSB first.
// A start pulse in IDLE loads the operands; WIDTH SHIFT cycles ripple the
// borrow through a one-bit register; DONE presents the result for one cycle.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             brr
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra;     // minuend; difference bits enter from the MSB side
    logic [WIDTH-1:0] rb;     // subtrahend, shifted right each SHIFT cycle
    logic             br;     // running borrow between bit positions
    logic [CW-1:0]    cnt;
    logic             d;
    logic             br_nxt;
    logic             last;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // Single-bit full-subtractor on the current LSBs.
    always_comb begin
        d      = ra[0] ^ rb[0] ^ br;
        br_nxt = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        last   = (cnt == LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath: operand load, serial shift, and the visible result registers
    // which only change on the final shift so they stay stable mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            brr  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    ra  <= {d, ra[WIDTH-1:1]};
                    rb  <= {1'b0, rb[WIDTH-1:1]};
                    br  <= br_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff <= {d, ra[WIDTH-1:1]};
                        brr  <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // d is the result MSB on the last shift.
                        ovf  <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed-vector bench for serial_sub with WIDTH=8.
// Build with +define+SERIAL_SUB_OVF_EN to also exercise the ovf output.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, brr;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] prev_diff = '0;
    logic         prev_brr = 1'b0;
    logic         prev_ovf = 1'b0;

    serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .brr(brr)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
        check(tag, 32'(ovf), 32'(exp));
`endif
    endtask

    // One full operation with exact cycle-by-cycle timing checks.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        start = 1'b1; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; a = ~xa; b = ~xb;
        check("busy_after_accept", 32'(busy), 32'd1);
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            check("done_low_shift", 32'(done), 32'd0);
            check("diff_hold_shift", 32'(diff), 32'(prev_diff));
            check("brr_hold_shift", 32'(brr), 32'(prev_brr));
            check_ovf("ovf_hold_shift", prev_ovf);
        end
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("diff", 32'(diff), 32'(ed));
        check("brr", 32'(brr), 32'(eb));
        check_ovf("ovf", eo);
        @(posedge clk); #1;
        check("done_fall", 32'(done), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        check("diff_held_idle", 32'(diff), 32'(ed));
        prev_diff = ed; prev_brr = eb; prev_ovf = eo;
    endtask

    initial begin
        int ndone;
        int cyc;
        // Reset and idle.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_brr", 32'(brr), 32'd0);
        check_ovf("rst_ovf", 1'b0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_diff", 32'(diff), 32'd0);
            check("idle_brr", 32'(brr), 32'd0);
        end

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Reset during shift 4 clears outputs at once.
        @(negedge clk); start = 1'b1; a = 8'h21; b = 8'h11;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_brr", 32'(brr), 32'd0);
        check_ovf("midrst_ovf", 1'b0);
        @(negedge clk); rst = 1'b0;
        prev_diff = '0; prev_brr = 1'b0; prev_ovf = 1'b0;
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        // start pulses during shift cycles 3 and 7 are ignored.
        @(negedge clk); start = 1'b1; a = 8'h09; b = 8'h04;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 7);
            a = 8'h01; b = 8'h02;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busystart_done", 32'(done), 32'd1);
        check("busystart_diff", 32'(diff), 32'h05);
        check("busystart_brr", 32'(brr), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("busystart_no_2nd_done", 32'(ndone), 32'd0);
        check("busystart_diff_kept", 32'(diff), 32'h05);

        // start held high: done after 8 edges, re-accept at edge k+W+2.
        @(negedge clk); start = 1'b1; a = 8'h0A; b = 8'h03;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held_latency", 32'(cyc), 32'(W));
        check("held_diff", 32'(diff), 32'h07);
        @(posedge clk); #1;
        check("held_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("held_reaccept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held_2nd_latency", 32'(cyc), 32'(W));
        check("held_2nd_diff", 32'(diff), 32'h07);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
